sig_scan: RTL and testbench
===========================

# sig_scan

Runtime-programmable multi-signature byte-stream scanner for cartridge bankswitch auto-detection. Sits beside the cart loader: the loader streams image bytes in, the scanner counts occurrences of up to NUM_SIGS byte signatures and reports per-signature hit flags once the image ends. It replaces fixed, compile-time signature matchers with a writable signature table, explicit scan framing and per-signature match thresholds.

## Interface
- NUM_SIGS, 8, number of signature lanes
- MAX_LEN, 5, maximum signature length in bytes
- CNT_W, 8, width of per-lane match counter and threshold
- ADDR_W, 13, width of image byte address
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- sig_wr  in  1  write strobe for signature table entry
- sig_idx  in  $clog2(NUM_SIGS)  lane written by sig_wr, also lane selected for query
- sig_pattern  in  MAX_LEN*8  pattern; byte 0 (bits 7:0) is the most recent stream byte
- sig_mask  in  MAX_LEN  byte-enable per pattern byte; all-zero disables the lane
- sig_need  in  CNT_W  matches required to set hit; 0 is treated as 1
- scan_start  in  1  begin a new scan; clears counts, hits, history
- in_valid  in  1  stream byte qualifier
- in_addr  in  ADDR_W  address of stream byte
- in_data  in  8  stream byte
- in_last  in  1  marks final byte of image, qualified by in_valid
- busy  out  1  scan in progress
- done  out  1  scan complete; results stable
- hit  out  NUM_SIGS  per-lane threshold reached
- q_count  out  CNT_W  match count of lane sig_idx
- q_first_addr  out  ADDR_W  in_addr of byte completing the first match of lane sig_idx

## Operation
- States: IDLE (reset), SCAN, DONE. IDLE/DONE -> SCAN on scan_start; SCAN -> DONE on accepted byte with in_last; SCAN -> SCAN (restart) on scan_start.
- Table writes (sig_wr) accepted only in IDLE/DONE; ignored in SCAN. Reset clears table: all lanes disabled.
- History: MAX_LEN-byte shift register plus fill counter (saturating at MAX_LEN); both cleared on scan_start.
- Match test per accepted byte uses history including the current byte: for every enabled mask bit k, window byte k equals pattern byte k. A bit k is only usable once fill > k; a match needing bytes before scan start never fires.
- Overlapping matches all count (pattern AA AA over AA AA AA = 2).
- Counter saturates at 2^CNT_W-1. hit[i] sets when count reaches max(sig_need,1) and stays set until scan_start.
- scan_start in the same cycle as in_valid: restart wins, byte dropped.
- in_valid outside SCAN ignored. in_addr only recorded, never checked for order.
- Reset values: busy=0, done=0, hit=0, q_count=0, q_first_addr=0, state IDLE.

## Timing
- Byte accepted at edge t; count, hit, first_addr visible after edge t (registered, one-cycle latency).
- done=1, busy=0 from the edge accepting the in_last byte; hit final at the same edge, including matches completed by that last byte.
- scan_start at edge t: busy=1, done=0, counts/hits cleared after t.
- q_count/q_first_addr combinational from lane registers via sig_idx mux.
- reset_n low mid-scan: immediate return to IDLE, table cleared.

## Configuration
- SIG_SCAN_FIRST_ADDR_EN: defined -> each lane holds an ADDR_W register loaded with in_addr on its first match per scan (cleared on scan_start); undefined -> no register, q_first_addr tied to 0.

## Structure
- Package sig_scan_pkg: state enum (IDLE, SCAN, DONE), default parameter constants, lane-entry struct (pattern, mask, need).
- Sub-module sig_scan_lane: one table entry, masked comparator, saturating counter, hit flag, optional first-address register; instantiated NUM_SIGS times by generate. Top holds FSM, history, fill counter, query mux.

## Test plan
- Lane 0 = 85 3F mask 00011 need 2; stream 85 3F 00 85 3F, last on final byte -> done next cycle, hit[0]=1, q_count=2.
- Lane 1 = AD E5 FF mask 00111 need 1; pattern straddles byte 0 of a new scan after previous scan ended AD E5 -> no hit; full AD E5 FF mid-stream -> hit[1]=1, q_first_addr = addr of FF (with _EN).
- Pattern AA AA need 3, stream AA x4 -> count 3, hit=1; CNT_W=8 stream of 300 matches -> q_count=255.
- Pattern completed by the in_last byte -> hit visible with done in the same cycle.
- sig_wr during SCAN -> table unchanged; scan_start with in_valid same cycle -> byte dropped, counts 0.
- reset_n low mid-scan -> busy=0, done=0, hit=0, all lanes disabled, no hits on subsequent scan.

Source files
------------

// File: rtl/sig_scan_pkg.sv
// Shared types and default sizes for the sig_scan signature scanner.
package sig_scan_pkg;

  localparam int unsigned NUM_SIGS_DEF = 8;
  localparam int unsigned ADDR_W_DEF   = 13;
  localparam int unsigned MAX_LEN      = 5;
  localparam int unsigned CNT_W        = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [MAX_LEN*8-1:0] pattern;
    logic [MAX_LEN-1:0]   mask;
    logic [CNT_W-1:0]     need;
  } lane_entry_t;

  // A zero threshold behaves like a threshold of one.
  function automatic logic [CNT_W-1:0] need_eff(input logic [CNT_W-1:0] need);
    need_eff = (need == '0) ? CNT_W'(1) : need;
  endfunction

endpackage

// File: rtl/sig_scan_lane.sv
// One signature lane: table entry, masked window comparator, saturating count, hit flag.
// With SIG_SCAN_FIRST_ADDR_EN the lane also records the address of its first match.
module sig_scan_lane
  import sig_scan_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wr_en,
  input  lane_entry_t          wr_entry,
  input  logic                 clear,
  input  logic                 accept,
  input  logic [MAX_LEN*8-1:0] window,
  input  logic [MAX_LEN-1:0]   usable,
  input  logic [ADDR_W-1:0]    addr,
  output logic [CNT_W-1:0]     count,
  output logic                 hit,
  output logic [ADDR_W-1:0]    first_addr
);

  lane_entry_t      entry_q;
  logic             match_c;
  logic [CNT_W-1:0] cnt_inc_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   entry_q <= '0;
    else if (wr_en) entry_q <= wr_entry;
  end

  // Every enabled byte must be present in this scan's history and equal.
  always_comb begin
    match_c = |entry_q.mask;
    for (int unsigned k = 0; k < MAX_LEN; k++) begin
      if (entry_q.mask[k] &&
          (!usable[k] || (window[8*k +: 8] != entry_q.pattern[8*k +: 8])))
        match_c = 1'b0;
    end
  end

  assign cnt_inc_c = (count == '1) ? count : count + CNT_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      hit   <= 1'b0;
    end else if (clear) begin
      count <= '0;
      hit   <= 1'b0;
    end else if (accept && match_c) begin
      count <= cnt_inc_c;
      if (cnt_inc_c >= need_eff(entry_q.need)) hit <= 1'b1;
    end
  end

`ifdef SIG_SCAN_FIRST_ADDR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                              first_addr <= '0;
    else if (clear)                            first_addr <= '0;
    else if (accept && match_c && count == '0) first_addr <= addr;
  end
`else
  logic unused_addr;
  assign unused_addr = ^addr;
  assign first_addr  = '0;
`endif

endmodule

// File: rtl/sig_scan.sv
// sig_scan: runtime-programmable multi-signature byte-stream scanner for cart auto-detection.
// Define SIG_SCAN_FIRST_ADDR_EN to report the first-match address of the queried lane.
module sig_scan
  import sig_scan_pkg::*;
#(
  parameter  int unsigned NUM_SIGS = NUM_SIGS_DEF,
  parameter  int unsigned ADDR_W   = ADDR_W_DEF,
  localparam int unsigned IDX_W    = (NUM_SIGS > 1) ? $clog2(NUM_SIGS) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sig_wr,
  input  logic [IDX_W-1:0]     sig_idx,
  input  logic [MAX_LEN*8-1:0] sig_pattern,
  input  logic [MAX_LEN-1:0]   sig_mask,
  input  logic [CNT_W-1:0]     sig_need,
  input  logic                 scan_start,
  input  logic                 in_valid,
  input  logic [ADDR_W-1:0]    in_addr,
  input  logic [7:0]           in_data,
  input  logic                 in_last,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_SIGS-1:0]  hit,
  output logic [CNT_W-1:0]     q_count,
  output logic [ADDR_W-1:0]    q_first_addr
);

  localparam int unsigned FILL_W = $clog2(MAX_LEN + 1);
  localparam int unsigned HIST_W = (MAX_LEN - 1) * 8;

  state_t               state_q, state_d;
  logic                 busy_d, done_d;
  logic                 accept_c, tbl_wr_c;
  logic [HIST_W-1:0]    hist_q;
  logic [FILL_W-1:0]    fill_q;
  logic [MAX_LEN*8-1:0] window_c;
  logic [MAX_LEN-1:0]   usable_c;
  lane_entry_t          wr_entry_c;
  logic [CNT_W-1:0]     cnt_a   [NUM_SIGS];
  logic [ADDR_W-1:0]    faddr_a [NUM_SIGS];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // A restart request always wins over a byte arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (scan_start) state_d = SCAN;
      SCAN: begin
        if (scan_start)                state_d = SCAN;
        else if (in_valid && in_last)  state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    accept_c = 1'b0;
    tbl_wr_c = 1'b0;
    busy_d   = (state_d == SCAN);
    done_d   = (state_d == DONE);
    case (state_q)
      SCAN:    accept_c = in_valid && !scan_start;
      default: tbl_wr_c = sig_wr;
    endcase
  end

  // Window byte 0 is the byte being accepted now, older bytes follow.
  assign window_c = {hist_q, in_data};

  always_comb begin
    usable_c = '0;
    for (int unsigned k = 0; k < MAX_LEN; k++) usable_c[k] = (32'(fill_q) >= k);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (scan_start) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (accept_c) begin
      hist_q <= window_c[HIST_W-1:0];
      if (fill_q != FILL_W'(MAX_LEN)) fill_q <= fill_q + FILL_W'(1);
    end
  end

  assign wr_entry_c = '{pattern: sig_pattern, mask: sig_mask, need: sig_need};

  for (genvar i = 0; i < NUM_SIGS; i++) begin : g_lane
    sig_scan_lane #(.ADDR_W(ADDR_W)) u_lane (
      .clk        (clk),
      .reset_n    (reset_n),
      .wr_en      (tbl_wr_c && (sig_idx == IDX_W'(i))),
      .wr_entry   (wr_entry_c),
      .clear      (scan_start),
      .accept     (accept_c),
      .window     (window_c),
      .usable     (usable_c),
      .addr       (in_addr),
      .count      (cnt_a[i]),
      .hit        (hit[i]),
      .first_addr (faddr_a[i])
    );
  end

  assign q_count      = cnt_a[sig_idx];
  assign q_first_addr = faddr_a[sig_idx];

endmodule

// File: tb/tb_sig_scan.sv
// Self-checking bench for sig_scan: stream-level reference model plus directed literal checks.
module tb_sig_scan;
  import sig_scan_pkg::*;

  localparam int unsigned NS = 8;

  logic        clk = 1'b0;
  logic        reset_n, sig_wr, scan_start, in_valid, in_last;
  logic [2:0]  sig_idx;
  logic [39:0] sig_pattern;
  logic [4:0]  sig_mask;
  logic [7:0]  sig_need, in_data;
  logic [12:0] in_addr;
  logic        busy, done;
  logic [7:0]  hit, q_count;
  logic [12:0] q_first_addr;

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          chk_en = 0;
  logic [12:0] next_addr = 13'h100;
  logic [12:0] a_ff;

  sig_scan dut (
    .clk(clk), .reset_n(reset_n), .sig_wr(sig_wr), .sig_idx(sig_idx),
    .sig_pattern(sig_pattern), .sig_mask(sig_mask), .sig_need(sig_need),
    .scan_start(scan_start), .in_valid(in_valid), .in_addr(in_addr),
    .in_data(in_data), .in_last(in_last), .busy(busy), .done(done), .hit(hit),
    .q_count(q_count), .q_first_addr(q_first_addr)
  );

  always #5 clk = ~clk;

  // Reference model: keeps the whole scan stream and tests its tail against each signature.
  logic [39:0] m_pat   [NS];
  logic [4:0]  m_mask  [NS];
  int          m_need  [NS];
  int          m_cnt   [NS];
  int          m_faddr [NS];
  logic [7:0]  m_hit;
  bit          m_scan, m_done;
  logic [7:0]  m_q [$];

  function automatic bit tail_matches(int i);
    int n;
    n = m_q.size();
    if (m_mask[i] == 5'b0) return 0;
    for (int k = 0; k < 5; k++) begin
      if (m_mask[i][k]) begin
        if (n <= k) return 0;
        if (m_q[n-1-k] != m_pat[i][8*k +: 8]) return 0;
      end
    end
    return 1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_scan = 0; m_done = 0; m_hit = '0; m_q.delete();
      for (int i = 0; i < NS; i++) begin
        m_pat[i] = '0; m_mask[i] = '0; m_need[i] = 0; m_cnt[i] = 0; m_faddr[i] = 0;
      end
    end else begin : m_step
      bit was_scan;
      was_scan = m_scan;
      if (sig_wr && !was_scan) begin
        m_pat[sig_idx]  = sig_pattern;
        m_mask[sig_idx] = sig_mask;
        m_need[sig_idx] = int'(sig_need);
      end
      if (scan_start) begin
        m_scan = 1; m_done = 0; m_hit = '0; m_q.delete();
        for (int i = 0; i < NS; i++) begin m_cnt[i] = 0; m_faddr[i] = 0; end
      end else if (was_scan && in_valid) begin
        m_q.push_back(in_data);
        for (int i = 0; i < NS; i++) begin
          if (tail_matches(i)) begin
            if (m_cnt[i] == 0) m_faddr[i] = int'(in_addr);
            if (m_cnt[i] < 255) m_cnt[i]++;
            if (m_cnt[i] >= ((m_need[i] == 0) ? 1 : m_need[i])) m_hit[i] = 1'b1;
          end
        end
        if (in_last) begin m_scan = 0; m_done = 1; end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",  32'(busy), 32'(m_scan));
      chk("done",  32'(done), 32'(m_done));
      chk("hit",   32'(hit),  32'(m_hit));
      chk("q_count", 32'(q_count), 32'(m_cnt[sig_idx]));
`ifdef SIG_SCAN_FIRST_ADDR_EN
      chk("q_first_addr", 32'(q_first_addr), 32'(m_faddr[sig_idx]));
`else
      chk("q_first_addr", 32'(q_first_addr), 32'd0);
`endif
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic wr_sig(input int idx, input logic [39:0] pat, input logic [4:0] msk, input int need);
    sig_wr = 1; sig_idx = 3'(idx); sig_pattern = pat; sig_mask = msk; sig_need = 8'(need);
    tick();
    sig_wr = 0;
  endtask

  task automatic start();
    scan_start = 1; next_addr = 13'h100;
    tick();
    scan_start = 0;
  endtask

  task automatic send(input logic [7:0] d, input bit last);
    in_valid = 1; in_data = d; in_addr = next_addr; in_last = last;
    next_addr = next_addr + 13'd1;
    tick();
    in_valid = 0; in_last = 0;
  endtask

  task automatic look(input int idx);
    sig_idx = 3'(idx); #1;
  endtask

  initial begin
    reset_n = 0; sig_wr = 0; scan_start = 0; in_valid = 0; in_last = 0;
    sig_idx = 0; sig_pattern = '0; sig_mask = '0; sig_need = '0; in_data = '0; in_addr = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hit",  32'(hit),  32'd0);
    chk("rst_cnt",  32'(q_count), 32'd0);
    reset_n = 1; chk_en = 1;
    tick();

    wr_sig(0, 40'h853F,   5'b00011, 2);
    wr_sig(1, 40'hADE5FF, 5'b00111, 1);
    wr_sig(2, 40'hAAAA,   5'b00011, 3);
    wr_sig(3, 40'hAAAA,   5'b00011, 0);

    // Second match completed by the final byte: hit appears together with done.
    start();
    send(8'h85, 0); send(8'h3F, 0); send(8'h00, 0); send(8'h85, 0); send(8'h3F, 1);
    look(0);
    chk("A_done", 32'(done), 32'd1);
    chk("A_busy", 32'(busy), 32'd0);
    chk("A_hit0", 32'(hit[0]), 32'd1);
    chk("A_cnt0", 32'(q_count), 32'd2);
    send(8'h85, 0); send(8'h3F, 1);
    chk("A_idle_bytes", 32'(q_count), 32'd2);

    // Signature straddling a scan boundary must not fire.
    start();
    send(8'h11, 0); send(8'hAD, 0); send(8'hE5, 1);
    start();
    send(8'hFF, 0); send(8'h22, 1);
    look(1);
    chk("B_hit1", 32'(hit[1]), 32'd0);
    chk("B_cnt1", 32'(q_count), 32'd0);

    start();
    send(8'h01, 0); send(8'hAD, 0); send(8'hE5, 0);
    a_ff = next_addr;
    send(8'hFF, 0); send(8'h02, 1);
    look(1);
    chk("C_hit1", 32'(hit[1]), 32'd1);
    chk("C_cnt1", 32'(q_count), 32'd1);
`ifdef SIG_SCAN_FIRST_ADDR_EN
    chk("C_faddr1", 32'(q_first_addr), 32'(a_ff));
`else
    chk("C_faddr1", 32'(q_first_addr), 32'd0);
`endif

    // Overlapping matches; zero threshold behaves as one.
    start();
    for (int i = 0; i < 4; i++) send(8'hAA, i == 3);
    look(2);
    chk("D_cnt2", 32'(q_count), 32'd3);
    chk("D_hit2", 32'(hit[2]), 32'd1);
    look(3);
    chk("D_cnt3", 32'(q_count), 32'd3);
    chk("D_hit3", 32'(hit[3]), 32'd1);

    // 300 matches saturate the 8-bit counter.
    start();
    for (int i = 0; i < 301; i++) send(8'hAA, i == 300);
    look(2);
    chk("E_cnt2", 32'(q_count), 32'd255);
    look(3);
    chk("E_cnt3", 32'(q_count), 32'd255);

    // Table write during a scan is ignored.
    start();
    wr_sig(0, 40'h3F3F, 5'b00011, 1);
    send(8'h85, 0); send(8'h3F, 0); send(8'h85, 0); send(8'h3F, 1);
    look(0);
    chk("F_cnt0", 32'(q_count), 32'd2);
    chk("F_hit0", 32'(hit[0]), 32'd1);

    // Restart in the same cycle as a byte: the byte is dropped.
    start();
    send(8'h85, 0);
    scan_start = 1; in_valid = 1; in_data = 8'h3F; in_addr = 13'h1FF;
    tick();
    scan_start = 0; in_valid = 0;
    look(0);
    chk("G_busy", 32'(busy), 32'd1);
    chk("G_cnt0", 32'(q_count), 32'd0);
    send(8'h00, 1);
    chk("G_cnt0_end", 32'(q_count), 32'd0);
    chk("G_hit0", 32'(hit[0]), 32'd0);

    // Asynchronous reset mid-scan clears status and table.
    start();
    send(8'h85, 0); send(8'h3F, 0); send(8'h85, 0); send(8'h3F, 0);
    chk("H_hit0_pre", 32'(hit[0]), 32'd1);
    reset_n = 0; #1;
    chk("H_busy", 32'(busy), 32'd0);
    chk("H_done", 32'(done), 32'd0);
    chk("H_hit",  32'(hit),  32'd0);
    tick();
    reset_n = 1;
    tick();
    start();
    send(8'h85, 0); send(8'h3F, 0); send(8'h85, 0); send(8'h3F, 0);
    for (int i = 0; i < 4; i++) send(8'hAA, 0);
    send(8'hAD, 0); send(8'hE5, 0); send(8'hFF, 1);
    chk("H_done_post", 32'(done), 32'd1);
    chk("H_hit_post",  32'(hit),  32'd0);

    tick();
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
